// File: rtl/uart_rx_wb.sv
// UART receiver (8N1, 16x oversampling) with an 8-bit receive FIFO behind a
// small Wishbone register map: DATA, STATUS, DIV and CTRL.

`timescale 1ns/1ps

`ifndef MPRJ_IO_PADS
`define MPRJ_IO_PADS 38
`endif

module uart_rx_wb #(
    parameter int          RX_PIN     = 8,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADR   = 32'h3000_0000
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       wbs_stb_i,
    input  logic                       wbs_cyc_i,
    input  logic                       wbs_we_i,
    input  logic [3:0]                 wbs_sel_i,
    input  logic [31:0]                wbs_adr_i,
    input  logic [31:0]                wbs_dat_i,
    output logic                       wbs_ack_o,
    output logic [31:0]                wbs_dat_o,
    input  logic [`MPRJ_IO_PADS-1:0]   io_in,
    output logic [`MPRJ_IO_PADS-1:0]   io_out,
    output logic [`MPRJ_IO_PADS-1:0]   io_oeb,
    output logic [2:0]                 irq
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_e;

    state_e state_q, state_d;

    logic              rx_meta_q, rx_sync_q;
    logic [15:0]       tick_cnt_q, tick_cnt_d;
    logic [3:0]        s_cnt_q, s_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [15:0]       div_q, div_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic              ovr_q, ovr_d;
    logic              ferr_q, ferr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              ack_q, ack_d;
    logic [31:0]       dat_q, dat_d;
    logic              irq_q, irq_d;
    logic [7:0]        mem_q [FIFO_DEPTH];

    logic              rx_en, irq_en, tick;
    logic              push, push_ok, pop, overrun_evt, ferr_set;
    logic              fifo_empty, fifo_full;
    logic              adr_match, wb_req, wb_wr, wb_rd;
    logic [1:0]        reg_sel;
    logic [7:0]        fifo_head;
    logic [31:0]       rdata;
    logic              unused_inputs;

    assign rx_en  = ctrl_q[0];
    assign irq_en = ctrl_q[1];

    assign unused_inputs = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i[31:16], io_in};

    assign io_out = '0;
    assign io_oeb = '1;
    assign irq    = {2'b00, irq_q};

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

    // FSM state register; dropping RX_EN is handled in the next-state logic.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!rx_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      if (!rx_sync_q) state_d = START;
                START:     if (tick && s_cnt_q == 4'd7) state_d = rx_sync_q ? IDLE : DATA;
                DATA:      if (tick && s_cnt_q == 4'd15 && bit_cnt_q == 3'd7) state_d = STOP;
                STOP:      if (tick && s_cnt_q == 4'd15) state_d = rx_sync_q ? IDLE : WAIT_HIGH;
                WAIT_HIGH: if (rx_sync_q) state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    // Sample counters, shift register and the push / frame-error strobes.
    always_comb begin
        s_cnt_d   = s_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        push      = 1'b0;
        ferr_set  = 1'b0;
        if (!rx_en) begin
            s_cnt_d   = 4'd0;
            bit_cnt_d = 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    s_cnt_d   = 4'd0;
                    bit_cnt_d = 3'd0;
                end
                START: begin
                    if (tick) s_cnt_d = (s_cnt_q == 4'd7) ? 4'd0 : s_cnt_q + 4'd1;
                end
                DATA: begin
                    if (tick) begin
                        s_cnt_d = s_cnt_q + 4'd1;
                        if (s_cnt_q == 4'd15) begin
                            shift_d   = {rx_sync_q, shift_q[7:1]};
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        s_cnt_d = s_cnt_q + 4'd1;
                        if (s_cnt_q == 4'd15) begin
                            push     = rx_sync_q;
                            ferr_set = !rx_sync_q;
                        end
                    end
                end
                default: s_cnt_d = 4'd0;
            endcase
        end
    end

    assign tick = rx_en && (tick_cnt_q >= div_q);

    always_comb begin
        tick_cnt_d = tick_cnt_q + 16'd1;
        if (!rx_en || tick) tick_cnt_d = 16'd0;
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                        (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign fifo_head  = mem_q[rd_ptr_q[ADDR_W-1:0]];

    assign adr_match = (wbs_adr_i[31:4] == BASE_ADR[31:4]);
    assign wb_req    = wbs_stb_i && wbs_cyc_i && !ack_q && adr_match;
    assign wb_wr     = wb_req && wbs_we_i;
    assign wb_rd     = wb_req && !wbs_we_i;
    assign reg_sel   = wbs_adr_i[3:2];

    // A pop frees a slot in the same cycle, so a push into a full FIFO is still accepted.
    assign pop         = wb_rd && (reg_sel == 2'd0) && !fifo_empty;
    assign push_ok     = push && (!fifo_full || pop);
    assign overrun_evt = push && fifo_full && !pop;

    always_comb begin
        rdata = 32'd0;
        case (reg_sel)
            2'd0: rdata = fifo_empty ? 32'd0 : {24'd0, fifo_head};
            2'd1: rdata = {28'd0, ferr_q, ovr_q, fifo_full, !fifo_empty};
            2'd2: rdata = {16'd0, div_q};
            2'd3: rdata = {30'd0, ctrl_q};
            default: rdata = 32'd0;
        endcase
    end

    always_comb begin
        div_d    = div_q;
        ctrl_d   = ctrl_q;
        ovr_d    = ovr_q;
        ferr_d   = ferr_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        ack_d    = wb_req;
        dat_d    = wb_rd ? rdata : 32'd0;
        if (wb_wr) begin
            case (reg_sel)
                2'd1: begin
                    if (wbs_dat_i[2]) ovr_d  = 1'b0;
                    if (wbs_dat_i[3]) ferr_d = 1'b0;
                end
                2'd2: div_d  = wbs_dat_i[15:0];
                2'd3: ctrl_d = wbs_dat_i[1:0];
                default: ;
            endcase
        end
        if (overrun_evt) ovr_d  = 1'b1;
        if (ferr_set)    ferr_d = 1'b1;
        irq_d = irq_en && (!fifo_empty || ovr_q || ferr_q);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            tick_cnt_q <= 16'd0;
            s_cnt_q    <= 4'd0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            div_q      <= 16'd0;
            ctrl_q     <= 2'd0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ack_q      <= 1'b0;
            dat_q      <= 32'd0;
            irq_q      <= 1'b0;
        end else begin
            rx_meta_q  <= io_in[RX_PIN];
            rx_sync_q  <= rx_meta_q;
            tick_cnt_q <= tick_cnt_d;
            s_cnt_q    <= s_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            div_q      <= div_d;
            ctrl_q     <= ctrl_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            irq_q      <= irq_d;
        end
    end

    // Storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge wb_clk_i) begin
        if (push_ok) mem_q[wr_ptr_q[ADDR_W-1:0]] <= shift_q;
    end

endmodule

// File: tb/tb_uart_rx_wb.sv
// Self-checking bench for uart_rx_wb: drives 8N1 frames on the rx pad and
// compares Wishbone reads against a queue-based receive model.

`timescale 1ns/1ps

`ifndef MPRJ_IO_PADS
`define MPRJ_IO_PADS 38
`endif

module tb_uart_rx_wb;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          DEPTH = 8;

    logic                      wb_clk_i = 1'b0;
    logic                      wb_rst_i;
    logic                      wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]                wbs_sel_i;
    logic [31:0]               wbs_adr_i, wbs_dat_i;
    logic                      wbs_ack_o;
    logic [31:0]               wbs_dat_o;
    logic [`MPRJ_IO_PADS-1:0]  io_in, io_out, io_oeb;
    logic [2:0]                irq;
    logic                      rx_line;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] exp_q [$];
    logic       exp_ovr, exp_ferr;

    assign io_in = {{(`MPRJ_IO_PADS-9){1'b0}}, rx_line, 8'h00};

    uart_rx_wb #(.RX_PIN(8), .FIFO_DEPTH(DEPTH), .BASE_ADR(BASE)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .wbs_stb_i(wbs_stb_i),
        .wbs_cyc_i(wbs_cyc_i),
        .wbs_we_i (wbs_we_i),
        .wbs_sel_i(wbs_sel_i),
        .wbs_adr_i(wbs_adr_i),
        .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o),
        .wbs_dat_o(wbs_dat_o),
        .io_in    (io_in),
        .io_out   (io_out),
        .io_oeb   (io_oeb),
        .irq      (irq)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation hung");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] expStatus();
        return {28'd0, exp_ferr, exp_ovr, exp_q.size() == DEPTH, exp_q.size() != 0};
    endfunction

    function automatic void modelRx(input logic [7:0] b, input logic stop_bit);
        if (!stop_bit)                  exp_ferr = 1'b1;
        else if (exp_q.size() == DEPTH) exp_ovr  = 1'b1;
        else                            exp_q.push_back(b);
    endfunction

    // Every bus access starts 1ns after a rising edge and expects ack after exactly one edge.
    task automatic wbAccess(input string tag, input logic we, input logic [3:0] off,
                            input logic [31:0] wdata, output logic [31:0] rdata);
        wbs_adr_i = BASE | {28'd0, off};
        wbs_dat_i = wdata;
        wbs_we_i  = we;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        @(posedge wb_clk_i); #1;
        checkOutput({tag, "_ack"}, {31'd0, wbs_ack_o}, 32'd1);
        rdata     = wbs_dat_o;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        @(posedge wb_clk_i); #1;
        checkOutput({tag, "_ackpulse"}, {31'd0, wbs_ack_o}, 32'd0);
        checkOutput({tag, "_datidle"}, wbs_dat_o, 32'd0);
    endtask

    task automatic wbWrite(input string tag, input logic [3:0] off, input logic [31:0] wdata);
        logic [31:0] dummy;
        wbAccess(tag, 1'b1, off, wdata, dummy);
    endtask

    task automatic readData(input string tag);
        logic [31:0] got, exp;
        exp = (exp_q.size() != 0) ? {24'd0, exp_q.pop_front()} : 32'd0;
        wbAccess(tag, 1'b0, 4'h0, 32'd0, got);
        checkOutput(tag, got, exp);
    endtask

    task automatic readReg(input string tag, input logic [3:0] off, input logic [31:0] exp);
        logic [31:0] got;
        wbAccess(tag, 1'b0, off, 32'd0, got);
        checkOutput(tag, got, exp);
    endtask

    task automatic checkStatus(input string tag);
        readReg(tag, 4'h4, expStatus());
    endtask

    // Drives one frame: start, 8 data bits LSB first, stop; line left high.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input int cpb);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_line = bits[i];
            repeat (cpb) @(posedge wb_clk_i);
            #1;
        end
        rx_line = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge wb_clk_i);
        #1;
    endtask

    initial begin
        wb_rst_i  = 1'b1;
        rx_line   = 1'b1;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'hF;
        wbs_adr_i = 32'd0;
        wbs_dat_i = 32'd0;
        exp_ovr   = 1'b0;
        exp_ferr  = 1'b0;
        idle(3);
        checkOutput("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
        checkOutput("rst_dat", wbs_dat_o, 32'd0);
        checkOutput("rst_irq", {29'd0, irq}, 32'd0);
        checkOutput("io_out", io_out[31:0], 32'd0);
        checkOutput("io_oeb", io_oeb[31:0], 32'hFFFF_FFFF);
        wb_rst_i = 1'b0;
        idle(2);
        checkStatus("rst_status");
        readReg("rst_div", 4'h8, 32'd0);
        readReg("rst_ctrl", 4'hC, 32'd0);

        // Single byte with interrupt
        wbWrite("div0", 4'h8, 32'd0);
        wbWrite("ctrl3", 4'hC, 32'd3);
        readReg("ctrl_rb", 4'hC, 32'd3);
        applyStimulus(8'hA5, 1'b1, 16);
        modelRx(8'hA5, 1'b1);
        idle(3);
        checkStatus("a5_status");
        checkOutput("a5_irq", {31'd0, irq[0]}, 32'd1);
        readData("a5_data");
        checkStatus("a5_status_empty");
        idle(2);
        checkOutput("a5_irq_clear", {29'd0, irq}, 32'd0);

        // Overrun
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(8'(i), 1'b1, 16);
            modelRx(8'(i), 1'b1);
        end
        idle(3);
        checkStatus("ovr_status");
        for (int i = 0; i < 9; i++) readData("ovr_data");
        checkOutput("ovr_irq", {31'd0, irq[0]}, 32'd1);
        wbWrite("ovr_clr", 4'h4, 32'h4);
        exp_ovr = 1'b0;
        checkStatus("ovr_cleared");

        // Framing error then recovery
        applyStimulus(8'h3C, 1'b0, 16);
        modelRx(8'h3C, 1'b0);
        rx_line = 1'b1;
        idle(20);
        checkStatus("ferr_status");
        applyStimulus(8'h55, 1'b1, 16);
        modelRx(8'h55, 1'b1);
        idle(3);
        checkStatus("ferr_then_55");
        readData("ferr_data55");
        wbWrite("ferr_clr", 4'h4, 32'h8);
        exp_ferr = 1'b0;
        checkStatus("ferr_cleared");

        // Start-bit glitch
        rx_line = 1'b0;
        idle(4);
        rx_line = 1'b1;
        idle(40);
        checkStatus("glitch_status");
        applyStimulus(8'h5A, 1'b1, 16);
        modelRx(8'h5A, 1'b1);
        idle(3);
        readData("glitch_next");

        // Pop coinciding with the push of a 9th byte into a full FIFO
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(8'(i), 1'b1, 16);
            modelRx(8'(i), 1'b1);
        end
        idle(3);
        checkStatus("full_status");
        fork
            applyStimulus(8'h09, 1'b1, 16);
            begin
                repeat (154) @(posedge wb_clk_i);
                #1;
                readData("simul_read");
            end
        join
        modelRx(8'h09, 1'b1);
        idle(3);
        checkStatus("simul_status");
        for (int i = 0; i < 8; i++) readData("simul_drain");

        // Reset mid-frame
        applyStimulus(8'h77, 1'b1, 16);
        modelRx(8'h77, 1'b1);
        idle(3);
        wbWrite("pre_rst_div", 4'h8, 32'd0);
        fork
            applyStimulus(8'hF0, 1'b1, 16);
            begin
                repeat (85) @(posedge wb_clk_i);
                #1;
                wb_rst_i = 1'b1;
                #1;
                checkOutput("async_irq", {29'd0, irq}, 32'd0);
                idle(2);
                wb_rst_i = 1'b0;
            end
        join
        exp_q.delete();
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
        idle(3);
        checkStatus("post_rst_status");
        readReg("post_rst_div", 4'h8, 32'd0);
        readReg("post_rst_ctrl", 4'hC, 32'd0);
        checkOutput("post_rst_irq", {29'd0, irq}, 32'd0);
        wbWrite("ctrl3b", 4'hC, 32'd3);
        applyStimulus(8'h81, 1'b1, 16);
        modelRx(8'h81, 1'b1);
        idle(3);
        checkStatus("rst_81_status");
        readData("rst_81_data");
        checkStatus("rst_81_empty");

        // Divider of 1 (32 clocks per bit)
        wbWrite("div1", 4'h8, 32'd1);
        readReg("div1_rb", 4'h8, 32'd1);
        applyStimulus(8'h96, 1'b1, 32);
        modelRx(8'h96, 1'b1);
        idle(3);
        readData("div1_data");

        // RX_EN dropped mid-frame
        fork
            applyStimulus(8'h3C, 1'b1, 32);
            begin
                repeat (100) @(posedge wb_clk_i);
                #1;
                wbWrite("rxen_off", 4'hC, 32'd2);
            end
        join
        idle(40);
        checkStatus("rxen_off_status");
        checkOutput("rxen_off_irq", {29'd0, irq}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
